// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from flops (plus flush), so back-pressure costs one register per stage.
module pipe_skid_stage #(
    parameter int unsigned        DATA_W  = 64,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter int unsigned        CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holding valid keeps its payload stable until the transfer happens.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic [DATA_W-1:0]  w_main_nxt;
    logic [DATA_W-1:0]  w_skid_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_main_valid;
    logic               w_skid_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stall_inc;

    assign w_main_valid = (r_state != S_EMPTY);
    assign w_skid_valid = (r_state == S_FULL);

    assign in_ready   = ~w_skid_valid & ~flush;
    assign out_valid  = w_main_valid & ~flush;
    assign out_data   = r_main;
    assign occ        = r_state;
    assign stall_cnt  = r_stall_cnt;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_stall_inc = out_valid & ~out_ready & (r_stall_cnt != {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main      <= NOP_VAL;
            r_skid      <= NOP_VAL;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VAL;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_HALF;
                        w_main_nxt  = in_data;
                    end
                end
                S_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = NOP_VAL;
                    end
                end
                S_FULL: begin
                    // The skid entry is older than anything upstream, so it refills main first.
                    if (w_out_fire) begin
                        w_state_nxt = S_HALF;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_VAL;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = NOP_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle plus directed literals.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] NOP = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [15:0]   stall_cnt;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occ;
  logic [2:0]    s_stall_cnt;

  int checks;
  int errors;

  // reference model: held entries oldest-first, plus stall counters
  logic [DW-1:0] exp_q[$];
  int            m_cnt;
  int            m_cnt_s;
  logic          m_in_fire;
  logic          m_out_fire;

  pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occ(s_occ), .stall_cnt(s_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one call = one cycle of inputs, applied just after the rising edge
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // model update on the same edge as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt   = 0;
      m_cnt_s = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_out_fire = (exp_q.size() > 0) && out_ready;
      m_in_fire  = in_valid && (exp_q.size() < 2);
      if ((exp_q.size() > 0) && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
      end
      if (m_out_fire) void'(exp_q.pop_front());
      if (m_in_fire) exp_q.push_back(in_data);
    end
  end

  // scoreboard compare, every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      logic [DW-1:0] e_data;
      e_data = (exp_q.size() > 0) ? exp_q[0] : NOP;
      chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0) && !flush});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) && !flush});
      chk("out_data", {16'd0, out_data}, {16'd0, e_data});
      chk("occ", {30'd0, occ}, exp_q.size());
      chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
      chk("s_out_data", {16'd0, s_out_data}, {16'd0, e_data});
      chk("s_stall_cnt", {29'd0, s_stall_cnt}, m_cnt_s);
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'hDEAD);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // streaming, one entry per cycle with one cycle of latency
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, DW'(k), 1'b1, 1'b0);
      @(negedge clk);
      if (k > 1) begin
        chk("stream_data", {16'd0, out_data}, k - 1);
        chk("stream_occ", {30'd0, occ}, 32'd1);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // back-pressure fills the skid slot
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_data", {16'd0, out_data}, 32'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_first", {16'd0, out_data}, 32'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_second", {16'd0, out_data}, 32'hB);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_empty_data", {16'd0, out_data}, 32'hDEAD);

    // flush while full, with input offered during the flush
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    drive(1'b1, 16'h000C, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_occ", {30'd0, occ}, 32'd0);
    chk("fl_data", {16'd0, out_data}, 32'hDEAD);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_not_captured", {30'd0, occ}, 32'd0);

    // stall counting and saturation of the narrow counter
    do_reset();
    drive(1'b1, 16'h0007, 1'b0, 1'b0);
    repeat (5) drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("stall5", {16'd0, stall_cnt}, 32'd5);
    chk("stall5_s", {29'd0, s_stall_cnt}, 32'd5);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("stall10", {16'd0, stall_cnt}, 32'd10);
    chk("stall10_s", {29'd0, s_stall_cnt}, 32'd7);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // random push/pop with occasional flush
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom),
            (i < 150) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset while full
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_occ", {30'd0, occ}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_data", {16'd0, out_data}, 32'hDEAD);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    #2 rst = 1'b0;
    drive(1'b1, 16'h0055, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("arst_push_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_push_data", {16'd0, out_data}, 32'h55);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
